dac_spi_driver: RTL
===================

// Module: dac_spi_driver
// PURPOSE
//  Downstream stage of the filter wrapper: accepts one LPF/HPF 16-bit sample pair per strobe
//  and serialises it to a dual-channel 12-bit SPI DAC as two 16-bit words (LPF->ch A, HPF->ch B).
//  Runs in the filter's sys_clk domain; SCLK is derived by clock-enable division, not a new clock.
// PARAMETERS
//  CLK_DIV  1  SCLK half-period in sys_clk cycles (>=1)
//  CS_GAP   2  CS_n high cycles between word A and word B (>=1)
// PORTS
//  sys_clk        in   1   system clock; all logic on posedge
//  sys_rst_n      in   1   asynchronous, active-low reset
//  i_sample_vld   in   1   one-cycle strobe: i_lpf_16bit/i_hpf_16bit valid
//  i_lpf_16bit    in   16  LPF sample; DAC code = bits [15:4]
//  i_hpf_16bit    in   16  HPF sample; DAC code = bits [15:4]
//  i_clr_overrun  in   1   clears o_overrun
//  o_dac_sclk     out  1   SPI clock, CPOL=0; DAC samples MOSI on rising edge
//  o_dac_mosi     out  1   SPI data, MSB first, changes only while SCLK low
//  o_dac_cs_n     out  1   SPI chip select, active low, one assertion per word
//  o_busy         out  1   frame in progress; strobes are not accepted
//  o_frame_done   out  1   one-cycle pulse on the cycle CS_n rises after word B
//  o_overrun      out  1   sticky: a strobe arrived while busy (that sample dropped)
// BEHAVIOUR
//  Reset (async, immediate): sclk=0, mosi=0, cs_n=1, busy=0, frame_done=0, overrun=0, FSM=IDLE.
//  Word format: {CMD[3:0], code[11:0]}; word A uses CMD_LPF=4'hC, word B uses CMD_HPF=4'h4.
//  FSM: IDLE -> WORD_A -> GAP -> WORD_B -> IDLE.
//   IDLE: i_sample_vld=1 latches both inputs into holding regs. On the next edge: cs_n=0,
//     busy=1, mosi=word A bit15, sclk=0, state=WORD_A.
//   WORD_x: 16 bit periods. Each period = H low cycles then H high cycles (H=CLK_DIV).
//     MOSI advances to the next bit on each falling edge. After the 16th high phase, cs_n=1
//     and sclk=0 on the same edge.
//   GAP: cs_n held high for CS_GAP cycles. The next edge enters WORD_B: cs_n=0,
//     mosi=word B bit15.
//   End of WORD_B: cs_n=1, busy=0, frame_done=1 for one cycle, mosi=0, state=IDLE.
//  Timing: each word holds cs_n low for exactly 32*H cycles. Frame = 64*H + CS_GAP cycles
//    from first cs_n fall to last cs_n rise (66 cycles with defaults).
//  A strobe arriving on the frame_done cycle is accepted, so cs_n stays high >=1 cycle
//    between frames.
//  Strobe while busy=1: sample ignored; o_overrun set on the next edge. It stays set until
//    i_clr_overrun. If set and clear coincide, set wins.
//  Inputs are sampled only at acceptance; input changes mid-frame have no effect.
//  Reset asserted mid-frame aborts the word immediately. No partial word is resumed after
//    reset is released.
// CONFIGURATION
//  `DAC_SPI_OFFSET_BIN_EN defined: inputs are two's complement; code = {~in[15], in[14:4]}
//    (offset binary, mid-scale 12'h800 for 0).
//  Not defined: code = in[15:4] unchanged (unsigned straight binary).
//  Framing, timing and handshake are identical in both builds.
// STRUCTURE
//  dac_spi_defs.vh: CMD_LPF, CMD_HPF, FSM state encodings, WORD_BITS=16.
//  Sub-module dac_spi_shifter: 16-bit load/shift register, H-cycle phase counter, bit counter,
//    sclk/mosi generation. Interface: load strobe + word in, word_done pulse out.
//  Top level: holding regs, code mapping (macro), FSM, cs_n, busy, overrun, frame_done.
// TESTING
//  1 Reset: hold sys_rst_n=0 -> cs_n=1, sclk=0, mosi=0, busy=0, overrun=0.
//  2 Nominal, defaults, macro off: lpf=16'hABC0, hpf=16'h1230, one strobe -> MOSI word A=16'hCABC,
//    word B=16'h4123 captured on sclk rises; cs_n low 32 cycles each, gap 2, frame_done at +66.
//  3 Macro on, same inputs -> word A=16'hC2BC, word B=16'h4923.
//  4 CLK_DIV=3: sclk high/low 3 cycles each; cs_n low 96 cycles per word; mosi is stable
//    across every rising edge.
//  5 Strobe at +10 of a busy frame -> overrun=1 and that sample is never transmitted.
//    Strobe on the frame_done cycle -> accepted, cs_n falls 1 cycle later.
//    clr+overrun together -> overrun stays 1.
//  6 Reset pulse mid word A -> outputs go to reset values asynchronously.
//    A new strobe after release -> clean full frame.

Source files
------------

// File: rtl/dac_spi_driver_pkg.sv
// Shared constants, FSM state type and word formatting for the dual-channel SPI DAC driver.
package dac_spi_driver_pkg;

   localparam int unsigned WORD_BITS = 16;
   localparam int unsigned CODE_BITS = 12;
   localparam int unsigned CMD_BITS  = WORD_BITS - CODE_BITS;

   localparam logic [CMD_BITS-1:0] CMD_LPF = 4'hC;
   localparam logic [CMD_BITS-1:0] CMD_HPF = 4'h4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WORD_A = 2'd1,
      ST_GAP    = 2'd2,
      ST_WORD_B = 2'd3
   } state_t;

   // DAC frame word: command nibble followed by the 12-bit code
   function automatic logic [WORD_BITS-1:0] make_word(input logic [CMD_BITS-1:0]  cmd,
                                                      input logic [CODE_BITS-1:0] code);
      return {cmd, code};
   endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample handshake and SPI pin bundle between the filter wrapper and the DAC driver.
interface dac_spi_driver_if;
   logic        i_sample_vld;
   logic [15:0] i_lpf_16bit;
   logic [15:0] i_hpf_16bit;
   logic        i_clr_overrun;
   logic        o_dac_sclk;
   logic        o_dac_mosi;
   logic        o_dac_cs_n;
   logic        o_busy;
   logic        o_frame_done;
   logic        o_overrun;

   modport slave (
      input  i_sample_vld, i_lpf_16bit, i_hpf_16bit, i_clr_overrun,
      output o_dac_sclk, o_dac_mosi, o_dac_cs_n, o_busy, o_frame_done, o_overrun
   );

   modport master (
      output i_sample_vld, i_lpf_16bit, i_hpf_16bit, i_clr_overrun,
      input  o_dac_sclk, o_dac_mosi, o_dac_cs_n, o_busy, o_frame_done, o_overrun
   );
endinterface

// File: rtl/dac_spi_driver_shifter.sv
// 16-bit SPI word serialiser: CLK_DIV-cycle half periods, MSB first, CPOL=0.
module dac_spi_driver_shifter
   import dac_spi_driver_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 i_load,
   input  logic [WORD_BITS-1:0] i_word,
   output logic                 o_sclk,
   output logic                 o_mosi,
   output logic                 o_word_done_c
);

   localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(WORD_BITS);

   logic [WORD_BITS-1:0] r_shift;
   logic [PH_W-1:0]      r_phase;
   logic [BIT_W-1:0]     r_bit;
   logic                 r_active;
   logic                 r_sclk;
   logic                 w_phase_end;

   assign w_phase_end   = r_active && (r_phase == PH_W'(CLK_DIV - 1));
   // Last edge of the 16th high phase: the top raises cs_n on this same edge
   assign o_word_done_c = w_phase_end && r_sclk && (r_bit == BIT_W'(WORD_BITS - 1));

   assign o_sclk = r_sclk;
   assign o_mosi = r_shift[WORD_BITS-1];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shift  <= '0;
         r_phase  <= '0;
         r_bit    <= '0;
         r_active <= 1'b0;
         r_sclk   <= 1'b0;
      end else if (i_load) begin
         r_shift  <= i_word;
         r_phase  <= '0;
         r_bit    <= '0;
         r_active <= 1'b1;
         r_sclk   <= 1'b0;
      end else if (r_active) begin
         if (!w_phase_end) begin
            r_phase <= PH_W'(r_phase + 1'b1);
         end else begin
            r_phase <= '0;
            if (!r_sclk) begin
               r_sclk <= 1'b1;
            end else if (o_word_done_c) begin
               r_active <= 1'b0;
               r_sclk   <= 1'b0;
               r_shift  <= '0;
            end else begin
               // Falling edge: next bit appears while sclk is low
               r_sclk  <= 1'b0;
               r_bit   <= BIT_W'(r_bit + 1'b1);
               r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/dac_spi_driver.sv
// LPF/HPF sample pair to dual-channel SPI DAC frame (word A then word B).
// Define DAC_SPI_OFFSET_BIN_EN to map two's complement inputs to offset-binary codes.
module dac_spi_driver
   import dac_spi_driver_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned CS_GAP  = 2
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   dac_spi_driver_if.slave    bus
);

   localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WORD_BITS-1:0]  r_hold_b;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic [GAP_W-1:0]      w_gap_cnt_nxt;
   logic                  r_cs_n;
   logic                  w_cs_n_nxt;
   logic                  r_busy;
   logic                  w_busy_nxt;
   logic                  r_frame_done;
   logic                  w_frame_done_nxt;
   logic                  r_overrun;
   logic                  w_accept;
   logic                  w_load;
   logic [WORD_BITS-1:0]  w_load_word;
   logic                  w_word_done_c;
   logic                  w_sclk;
   logic                  w_mosi;
   logic [CODE_BITS-1:0]  w_code_lpf_c;
   logic [CODE_BITS-1:0]  w_code_hpf_c;
   logic                  w_unused_c;

`ifdef DAC_SPI_OFFSET_BIN_EN
   assign w_code_lpf_c = {~bus.i_lpf_16bit[15], bus.i_lpf_16bit[14:4]};
   assign w_code_hpf_c = {~bus.i_hpf_16bit[15], bus.i_hpf_16bit[14:4]};
`else
   assign w_code_lpf_c = bus.i_lpf_16bit[15:4];
   assign w_code_hpf_c = bus.i_hpf_16bit[15:4];
`endif

   // Sub-LSB input bits are below DAC resolution
   assign w_unused_c = ^{bus.i_lpf_16bit[3:0], bus.i_hpf_16bit[3:0]};

   dac_spi_driver_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .i_load        (w_load),
      .i_word        (w_load_word),
      .o_sclk        (w_sclk),
      .o_mosi        (w_mosi),
      .o_word_done_c (w_word_done_c)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_gap_cnt_nxt    = r_gap_cnt;
      w_cs_n_nxt       = r_cs_n;
      w_busy_nxt       = r_busy;
      w_frame_done_nxt = 1'b0;
      w_accept         = 1'b0;
      w_load           = 1'b0;
      w_load_word      = r_hold_b;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_sample_vld) begin
               w_accept    = 1'b1;
               w_load      = 1'b1;
               w_load_word = make_word(CMD_LPF, w_code_lpf_c);
               w_cs_n_nxt  = 1'b0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_WORD_A;
            end
         end
         ST_WORD_A: begin
            if (w_word_done_c) begin
               w_cs_n_nxt    = 1'b1;
               w_gap_cnt_nxt = '0;
               w_state_nxt   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == GAP_W'(CS_GAP - 1)) begin
               w_load      = 1'b1;
               w_cs_n_nxt  = 1'b0;
               w_state_nxt = ST_WORD_B;
            end else begin
               w_gap_cnt_nxt = GAP_W'(r_gap_cnt + 1'b1);
            end
         end
         ST_WORD_B: begin
            if (w_word_done_c) begin
               w_cs_n_nxt       = 1'b1;
               w_busy_nxt       = 1'b0;
               w_frame_done_nxt = 1'b1;
               w_state_nxt      = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Holding register, framing outputs and sticky overrun (set beats clear)
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_hold_b     <= '0;
         r_gap_cnt    <= '0;
         r_cs_n       <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold_b <= make_word(CMD_HPF, w_code_hpf_c);
         end
         r_gap_cnt    <= w_gap_cnt_nxt;
         r_cs_n       <= w_cs_n_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_overrun    <= (bus.i_sample_vld & r_busy) | (r_overrun & ~bus.i_clr_overrun);
      end
   end

   assign bus.o_dac_sclk   = w_sclk;
   assign bus.o_dac_mosi   = w_mosi;
   assign bus.o_dac_cs_n   = r_cs_n;
   assign bus.o_busy       = r_busy;
   assign bus.o_frame_done = r_frame_done;
   assign bus.o_overrun    = r_overrun;

endmodule
